receive_control: RTL

Packet-level receive controller: the receiving end of the 8-byte framed link whose transmit side sends START, ID, FUNC, PAYLOAD1-3, ENDING and CRC bytes, MSB-first from a 64-bit word. It sits between the byte-level UART receiver and the configuration logic. It checks the framing, the end marker and the CRC-8 of each packet, then reassembles the bytes into one 64-bit word. It reports each packet as either good or errored.

---
 rtl/receive_control_pkg.sv | 37 +++
 rtl/receive_control_if.sv | 22 ++
 rtl/receive_control_crc8_byte.sv | 19 +
 rtl/receive_control.sv | 116 +++++++++++
 4 files changed

// File: rtl/receive_control_pkg.sv
// Shared definitions for the framed 8-byte link: state encoding, error codes,
// CRC polynomial and byte-slot positions used by both link directions.
package receive_control_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ID     = 4'd1;
  localparam logic [3:0] ST_FUNC   = 4'd2;
  localparam logic [3:0] ST_PAY1   = 4'd3;
  localparam logic [3:0] ST_PAY2   = 4'd4;
  localparam logic [3:0] ST_PAY3   = 4'd5;
  localparam logic [3:0] ST_ENDING = 4'd6;
  localparam logic [3:0] ST_CRC    = 4'd7;
  localparam logic [3:0] ST_CHECK  = 4'd8;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_END     = 2'b01;
  localparam logic [1:0] ERR_CRC     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Byte slot N occupies bits [N*8+7 : N*8] of the 64-bit packet word.
  localparam logic [2:0] SLOT_START  = 3'd7;
  localparam logic [2:0] SLOT_ID     = 3'd6;
  localparam logic [2:0] SLOT_FUNC   = 3'd5;
  localparam logic [2:0] SLOT_PAY1   = 3'd4;
  localparam logic [2:0] SLOT_PAY2   = 3'd3;
  localparam logic [2:0] SLOT_PAY3   = 3'd2;
  localparam logic [2:0] SLOT_ENDING = 3'd1;
  localparam logic [2:0] SLOT_CRC    = 3'd0;

  // Receive states ID..CRC map one-to-one onto slots 6..0.
  function automatic logic [2:0] slot_of_state(input logic [3:0] st);
    return SLOT_START - st[2:0];
  endfunction

endpackage

// File: rtl/receive_control_if.sv
// Byte-stream input and packet-result outputs of the receive controller.
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, so every strobe is either consumed or deliberately dropped.
interface receive_control_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [63:0] data_out;
  logic        packet_valid;
  logic        packet_error;
  logic [1:0]  error_code;
  logic        busy;

  modport master (
    output rx_valid, rx_data,
    input  data_out, packet_valid, packet_error, error_code, busy
  );

  modport slave (
    input  rx_valid, rx_data,
    output data_out, packet_valid, packet_error, error_code, busy
  );
endinterface

// File: rtl/receive_control_crc8_byte.sv
// One-byte CRC-8 step (poly 0x07, MSB-first, unreflected); shared with the
// transmit-side generator.
module crc8_byte
  import receive_control_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);
  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end
endmodule

// File: rtl/receive_control.sv
// Packet receiver: frames 8 bytes, checks the end marker, inter-byte timeout
// and CRC-8, and publishes good packets on data_out.
module receive_control
  import receive_control_pkg::*;
#(
  parameter logic [7:0]  START_BYTE     = 8'h11,
  parameter logic [7:0]  END_BYTE       = 8'h11,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                rst,
  receive_control_if.slave    bus,
  output logic [3:0]          dbg_state_o
);
  localparam int unsigned     CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   CNT_TO  = CW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    state_q, state_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [63:0]   data_q, data_d;
  logic [7:0]    crc_q, crc_d, crc_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pv_q, pv_d, pe_q, pe_d, busy_q;
  logic [1:0]    ec_q, ec_d;
  logic [2:0]    slot;

  crc8_byte u_crc (.crc_in(crc_q), .data(bus.rx_data), .crc_out(crc_next));

  assign slot = slot_of_state(state_q);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    pv_d     = 1'b0;
    pe_d     = 1'b0;
    ec_d     = ec_q;
    case (state_q)
      ST_IDLE: begin
        crc_d = 8'h00;
        cnt_d = '0;
        if (bus.rx_valid && bus.rx_data == START_BYTE) begin
          shadow_d[63:56] = bus.rx_data;
          state_d         = ST_ID;
        end
      end
      ST_ID, ST_FUNC, ST_PAY1, ST_PAY2, ST_PAY3, ST_ENDING, ST_CRC: begin
        if (bus.rx_valid) begin
          cnt_d = '0;
          shadow_d[{slot, 3'b000} +: 8] = bus.rx_data;
          if (state_q <= ST_PAY3) crc_d = crc_next;
          if (state_q == ST_ENDING && bus.rx_data != END_BYTE) begin
            pe_d    = 1'b1;
            ec_d    = ERR_END;
            state_d = ST_IDLE;
          end else begin
            state_d = state_q + 4'd1;
          end
        end else if (cnt_q >= CNT_TO) begin
          // A strobe in this very cycle would have won above.
          pe_d    = 1'b1;
          ec_d    = ERR_TIMEOUT;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (shadow_q[7:0] == crc_q) begin
          data_d = shadow_q;
          pv_d   = 1'b1;
        end else begin
          pe_d = 1'b1;
          ec_d = ERR_CRC;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      data_q   <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      pv_q     <= 1'b0;
      pe_q     <= 1'b0;
      ec_q     <= ERR_NONE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      pv_q     <= pv_d;
      pe_q     <= pe_d;
      ec_q     <= ec_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign bus.data_out     = data_q;
  assign bus.packet_valid = pv_q;
  assign bus.packet_error = pe_q;
  assign bus.error_code   = ec_q;
  assign bus.busy         = busy_q;
  assign dbg_state_o      = state_q;
endmodule
